// File: rtl/counter_pkg.sv
// Shared constants, FSM encodings and the nibble-to-ASCII helper for the
// counter UART reader.
package counter_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int CHARS_PER_FRAME      = 10;

  typedef enum logic [1:0] {
    TOP_IDLE = 2'd0,
    TOP_LOAD = 2'd1,
    TOP_WAIT = 2'd2,
    TOP_FIN  = 2'd3
  } top_state_t;

  typedef enum logic [1:0] {
    BYTE_IDLE  = 2'd0,
    BYTE_START = 2'd1,
    BYTE_DATA  = 2'd2,
    BYTE_STOP  = 2'd3
  } byte_state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) begin
      res = ASCII_ZERO + {4'd0, nib};
    end else begin
      res = ASCII_A + ({4'd0, nib} - 8'd10);
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. TXD is registered from the current state, so the line
// lags the state machine by one cycle uniformly for every bit.
module uart_byte_tx
  import counter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       TXD
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  byte_state_t       r_state;
  byte_state_t       w_next_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_data;
  logic              r_txd;
  logic              w_bit_end;
  logic              w_take;

  // Ready also rises in the last STOP cycle so the next byte starts with no gap.
  always_comb begin
    w_bit_end    = (r_baud == BAUD_LAST);
    in_ready     = 1'b0;
    w_next_state = r_state;
    case (r_state)
      BYTE_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = BYTE_START;
        else          w_next_state = BYTE_IDLE;
      end
      BYTE_START: begin
        if (w_bit_end) w_next_state = BYTE_DATA;
        else           w_next_state = BYTE_START;
      end
      BYTE_DATA: begin
        if (w_bit_end && (r_bit == 3'd7)) w_next_state = BYTE_STOP;
        else                              w_next_state = BYTE_DATA;
      end
      BYTE_STOP: begin
        if (w_bit_end) begin
          in_ready = 1'b1;
          if (in_valid) w_next_state = BYTE_START;
          else          w_next_state = BYTE_IDLE;
        end else begin
          w_next_state = BYTE_STOP;
        end
      end
      default: w_next_state = BYTE_IDLE;
    endcase
    w_take = in_valid && in_ready;
  end

  always_ff @(posedge CLK) begin
    if (!R) r_state <= BYTE_IDLE;
    else    r_state <= w_next_state;
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      r_baud <= {BAUD_W{1'b0}};
      r_bit  <= 3'd0;
      r_data <= 8'd0;
      r_txd  <= 1'b1;
    end else begin
      case (r_state)
        BYTE_IDLE:  r_txd <= 1'b1;
        BYTE_START: r_txd <= 1'b0;
        BYTE_DATA:  r_txd <= r_data[r_bit];
        BYTE_STOP:  r_txd <= 1'b1;
        default:    r_txd <= 1'b1;
      endcase
      if (w_take) begin
        r_data <= in_data;
        r_baud <= {BAUD_W{1'b0}};
        r_bit  <= 3'd0;
      end else if (r_state != BYTE_IDLE) begin
        r_baud <= w_bit_end ? {BAUD_W{1'b0}} : r_baud + BAUD_W'(1);
        if ((r_state == BYTE_DATA) && w_bit_end) r_bit <= r_bit + 3'd1;
      end
    end
  end

  assign TXD = r_txd;

endmodule

// File: rtl/counter_uart_tx.sv
// Snapshots Q_IN on request and sends it as 8 uppercase hex characters plus
// CR LF over an 8N1 UART line.
module counter_uart_tx
  import counter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 32
) (
  input  logic              CLK,
  input  logic              R,
  input  logic [DATA_W-1:0] Q_IN,
  input  logic              SEND,
  output logic              BUSY,
  output logic              DONE,
  output logic              TXD
);

  localparam logic [3:0] IDX_END = 4'(CHARS_PER_FRAME);

  top_state_t        r_state;
  top_state_t        w_next_state;
  logic [DATA_W-1:0] r_snap;
  logic [3:0]        r_idx;
  logic              r_busy;
  logic              r_done;
  logic              w_valid;
  logic              w_ready;
  logic              w_take;
  logic              w_accept;
  logic [7:0]        w_char;

  always_comb begin
    w_char = ASCII_LF;
    case (r_idx)
      4'd0:    w_char = hex_ascii(r_snap[31:28]);
      4'd1:    w_char = hex_ascii(r_snap[27:24]);
      4'd2:    w_char = hex_ascii(r_snap[23:20]);
      4'd3:    w_char = hex_ascii(r_snap[19:16]);
      4'd4:    w_char = hex_ascii(r_snap[15:12]);
      4'd5:    w_char = hex_ascii(r_snap[11:8]);
      4'd6:    w_char = hex_ascii(r_snap[7:4]);
      4'd7:    w_char = hex_ascii(r_snap[3:0]);
      4'd8:    w_char = ASCII_CR;
      4'd9:    w_char = ASCII_LF;
      default: w_char = ASCII_LF;
    endcase
  end

  // r_idx is the next character to hand off; WAIT offers it while the byte
  // serialiser is busy so it is taken in the last stop cycle with zero gap.
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      TOP_IDLE: begin
        if (SEND) begin
          w_accept     = 1'b1;
          w_next_state = TOP_LOAD;
        end else begin
          w_next_state = TOP_IDLE;
        end
      end
      TOP_LOAD: begin
        w_valid = 1'b1;
        if (w_ready) w_next_state = TOP_WAIT;
        else         w_next_state = TOP_LOAD;
      end
      TOP_WAIT: begin
        if (r_idx == IDX_END) begin
          if (w_ready) w_next_state = TOP_FIN;
          else         w_next_state = TOP_WAIT;
        end else begin
          w_valid      = 1'b1;
          w_next_state = TOP_WAIT;
        end
      end
      TOP_FIN:  w_next_state = TOP_IDLE;
      default:  w_next_state = TOP_IDLE;
    endcase
    w_take = w_valid && w_ready;
  end

  always_ff @(posedge CLK) begin
    if (!R) r_state <= TOP_IDLE;
    else    r_state <= w_next_state;
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      r_snap <= {DATA_W{1'b0}};
      r_idx  <= 4'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == TOP_FIN);
      if (w_accept) begin
        r_snap <= Q_IN;
        r_idx  <= 4'd0;
        r_busy <= 1'b1;
      end else if (r_state == TOP_FIN) begin
        r_busy <= 1'b0;
      end else if (w_take) begin
        r_idx <= r_idx + 4'd1;
      end else begin
        r_busy <= r_busy;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .CLK     (CLK),
    .R       (R),
    .in_valid(w_valid),
    .in_ready(w_ready),
    .in_data (w_char),
    .TXD     (TXD)
  );

  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_counter_uart_tx.sv
// Self-checking bench: two instances (4 and 2 clocks per bit) checked against
// a line-level model built from the character list and 8N1 framing rules.
module tb_counter_uart_tx;

  logic        clk = 1'b0;
  logic        R;
  logic [31:0] Q_IN;
  logic        send4, send2;
  logic        busy4, done4, txd4;
  logic        busy2, done2, txd2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(32)) u_dut4 (
    .CLK(clk), .R(R), .Q_IN(Q_IN), .SEND(send4),
    .BUSY(busy4), .DONE(done4), .TXD(txd4)
  );

  counter_uart_tx #(.CLKS_PER_BIT(2), .DATA_W(32)) u_dut2 (
    .CLK(clk), .R(R), .Q_IN(Q_IN), .SEND(send2),
    .BUSY(busy2), .DONE(done2), .TXD(txd2)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [79:0] exp;
    logic        chg_q;
    logic        poke;
  } vec_t;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] model_chars(input logic [31:0] q);
    logic [79:0] s;
    int nib;
    for (int k = 0; k < 8; k++) begin
      nib = int'((q >> (28 - 4 * k)) & 32'hF);
      s[79 - 8 * k -: 8] = (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
    end
    s[15:8] = 8'h0D;
    s[7:0]  = 8'h0A;
    return s;
  endfunction

  // Expected line level t cycles after the first start-bit fall.
  function automatic logic exp_bit(input logic [79:0] s, input int cpb, input int t);
    int k, b;
    logic [7:0] ch;
    if (t >= 100 * cpb) return 1'b1;
    k  = t / (10 * cpb);
    b  = (t % (10 * cpb)) / cpb;
    ch = s[79 - 8 * k -: 8];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ch[b - 1];
  endfunction

  task automatic start_send(input int sel, input logic [31:0] q);
    Q_IN = q;
    if (sel == 1) send2 = 1'b1;
    else          send4 = 1'b1;
  endtask

  // Caller has raised SEND at a negedge; the next posedge is the accept edge.
  task automatic run_frame(input string tag, input int sel, input logic [31:0] q,
                           input logic [79:0] exp, input logic hold,
                           input logic chg_q, input logic poke);
    int cpb, nlen, busy_cnt, done_cnt, done_at, wave_err, poke_n;
    logic tx, bz, dn, pre1, pre2;
    logic smp[$];
    logic [79:0] dec;
    cpb = (sel == 1) ? 2 : 4;
    nlen = 100 * cpb;
    poke_n = 3 + 30 * cpb + 1;
    busy_cnt = 0; done_cnt = 0; done_at = -1; wave_err = 0;
    pre1 = 1'bx; pre2 = 1'bx;
    @(posedge clk);
    for (int n = 1; n <= nlen + 3; n++) begin
      @(negedge clk);
      tx = (sel == 1) ? txd2 : txd4;
      bz = (sel == 1) ? busy2 : busy4;
      dn = (sel == 1) ? done2 : done4;
      if (n == 1 && !hold) begin send4 = 1'b0; send2 = 1'b0; end
      if (n == 1 && chg_q) Q_IN = ~q;
      if (poke && n == poke_n)     begin if (sel == 1) send2 = 1'b1; else send4 = 1'b1; end
      if (poke && n == poke_n + 1) begin if (sel == 1) send2 = 1'b0; else send4 = 1'b0; end
      if (bz) busy_cnt++;
      if (dn) begin done_cnt++; done_at = n; end
      if (n == 1) pre1 = tx;
      else if (n == 2) pre2 = tx;
      else smp.push_back(tx);
    end
    for (int t = 0; t <= nlen; t++)
      if (smp[t] !== exp_bit(exp, cpb, t)) wave_err++;
    dec = '0;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 8; j++)
        dec[72 - 8 * k + j] = smp[10 * cpb * k + cpb * (1 + j) + cpb / 2];
    chk({tag, "_latency"}, 80'({pre1, pre2, smp[0]}), 80'(3'b110));
    chk({tag, "_wave_errs"}, 80'(wave_err), 80'(0));
    chk({tag, "_decoded"}, dec, exp);
    chk({tag, "_busy_cycles"}, 80'(busy_cnt), 80'(nlen + 2));
    chk({tag, "_done_pulses"}, 80'(done_cnt), 80'(1));
    chk({tag, "_done_at"}, 80'(done_at), 80'(nlen + 3));
    if (!hold) begin
      @(negedge clk);
      bz = (sel == 1) ? busy2 : busy4;
      dn = (sel == 1) ? done2 : done4;
      chk({tag, "_idle_after"}, 80'({bz, dn}), 80'(2'b00));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[4];
    logic [31:0] rq;
    int          rst_n;

    tbl[0] = '{32'h0000_00A5, {"000000A5", 8'h0D, 8'h0A}, 1'b0, 1'b0};
    tbl[1] = '{32'hDEAD_BEEF, {"DEADBEEF", 8'h0D, 8'h0A}, 1'b1, 1'b0};
    tbl[2] = '{32'h9ABC_0F31, {"9ABC0F31", 8'h0D, 8'h0A}, 1'b0, 1'b1};
    tbl[3] = '{32'h0000_0000, {"00000000", 8'h0D, 8'h0A}, 1'b1, 1'b1};

    R = 1'b0; send4 = 1'b0; send2 = 1'b0; Q_IN = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_txd4", 80'(txd4), 80'(1));
    chk("reset_busy4", 80'(busy4), 80'(0));
    chk("reset_done4", 80'(done4), 80'(0));
    chk("reset_txd2", 80'(txd2), 80'(1));
    chk("reset_busy2", 80'(busy2), 80'(0));
    R = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      start_send(0, tbl[i].q);
      run_frame($sformatf("tbl%0d", i), 0, tbl[i].q, tbl[i].exp, 1'b0, tbl[i].chg_q, tbl[i].poke);
    end

    for (int i = 0; i < 4; i++) begin
      rq = $urandom;
      start_send(0, rq);
      run_frame($sformatf("rand%0d", i), 0, rq, model_chars(rq), 1'b0, 1'b0, 1'b0);
    end

    // SEND held high: two back-to-back frames, three idle-high cycles between.
    start_send(0, 32'h1234_5678);
    run_frame("hold_a", 0, 32'h1234_5678, {"12345678", 8'h0D, 8'h0A}, 1'b1, 1'b0, 1'b0);
    run_frame("hold_b", 0, 32'h1234_5678, {"12345678", 8'h0D, 8'h0A}, 1'b0, 1'b0, 1'b0);

    // Reset during data bit 2 of character 5 (a '0', whose bit 2 is low).
    rst_n = 3 + 53 * 4;
    start_send(0, 32'h0000_0000);
    @(posedge clk);
    for (int n = 1; n <= rst_n; n++) begin
      @(negedge clk);
      if (n == 1) send4 = 1'b0;
    end
    chk("midreset_busy_before", 80'(busy4), 80'(1));
    chk("midreset_txd_before", 80'(txd4), 80'(0));
    R = 1'b0;
    @(negedge clk);
    chk("midreset_txd", 80'(txd4), 80'(1));
    chk("midreset_busy", 80'(busy4), 80'(0));
    chk("midreset_done", 80'(done4), 80'(0));
    R = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_stays_idle", 80'({txd4, busy4}), 80'(2'b10));
    rq = $urandom;
    start_send(0, rq);
    run_frame("after_reset", 0, rq, model_chars(rq), 1'b0, 1'b0, 1'b0);

    start_send(1, 32'hFFFF_FFFF);
    run_frame("cpb2_ff", 1, 32'hFFFF_FFFF, {"FFFFFFFF", 8'h0D, 8'h0A}, 1'b0, 1'b0, 1'b0);
    rq = $urandom;
    start_send(1, rq);
    run_frame("cpb2_rand", 1, rq, model_chars(rq), 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
